// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared types and constants for the load/store unit.
//             Holds the FSM state enum, the RV32I load/store funct3 size
//             encodings and a helper that checks whether a funct3 value is
//             legal for a load or for a store.
//  Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // Stores only have B/H/W; loads additionally have the unsigned forms.
  function automatic logic funct3_ok(input logic [2:0] f3, input logic is_store);
    logic ok;
    ok = 1'b0;
    case (f3)
      LSU_B, LSU_H, LSU_W: ok = 1'b1;
      LSU_BU, LSU_HU:      ok = ~is_store;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_align
//  Purpose  : Combinational lane logic for the LSU.
//             Store side: byte-enable generation and write-data replication
//             from the (already size-aligned) address offset.
//             Load side : selects the addressed byte/halfword from the
//             captured memory word and sign/zero extends it.
//  Ports    : st_funct3/st_off/st_data -> be, wdata
//             ld_funct3/ld_off/rdata   -> ld_data
//  Revision : 1.0  initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Lane replication means the memory sees the right value whatever lane
  // the byte enables select.
  always_comb begin
    be    = 4'b1111;
    wdata = st_data;
    case (st_funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << st_off;
        wdata = {4{st_data[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << {st_off[1], 1'b0};
        wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = rdata[7:0];
    case (ld_off)
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      2'd3:    ld_byte = rdata[31:24];
      default: ld_byte = rdata[7:0];
    endcase
    ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
    ld_data = 32'h0;
    case (ld_funct3)
      LSU_B:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      LSU_BU:  ld_data = {24'h0, ld_byte};
      LSU_H:   ld_data = {{16{ld_half[15]}}, ld_half};
      LSU_HU:  ld_data = {16'h0, ld_half};
      LSU_W:   ld_data = rdata;
      default: ld_data = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
//  Module   : lsu
//  Purpose  : Load/store unit. Accepts one load or store from execute,
//             issues a single registered memory request, waits for ack
//             (with timeout) and pulses o_done with the extended load data.
//  Ports    : i_clk, i_rst (sync, active high)
//             execute side : i_valid, i_lsu_rden, i_lsu_wren, i_funct3,
//                            i_alu_data, i_rs2_data -> o_ready, o_done,
//                            o_ld_data, o_err, o_misalign
//             memory side  : o_mem_req/we/addr/wdata/be, i_mem_ack/rdata
//  Config   : LSU_MISALIGN_TRAP_EN - trap misaligned H/W accesses instead
//             of silently clearing the low address bits.
//  Revision : 1.0  initial release
// ============================================================================
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_lsu_rden,
  input  logic        i_lsu_wren,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_alu_data,
  input  logic [31:0] i_rs2_data,
  output logic        o_ready,
  output logic        o_done,
  output logic [31:0] o_ld_data,
  output logic        o_err,
  output logic        o_misalign,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state, state_nx;
  logic          accept, is_store_in, bad_f3, misalign_in, trap;
  logic [1:0]    off_in;
  logic [CW-1:0] tmo_cnt;
  logic          timeout;
  logic          is_store, err_q, mis_q;
  logic [2:0]    funct3_q;
  logic [1:0]    off_q;
  logic [31:0]   rdata_q;
  logic [3:0]    be_nx;
  logic [31:0]   wdata_nx, ld_ext;

  assign accept      = (state == IDLE) && i_valid && (i_lsu_rden || i_lsu_wren);
  assign is_store_in = i_lsu_wren;  // rden+wren together is a store
  assign bad_f3      = ~funct3_ok(i_funct3, is_store_in);

  // Offset forced to the natural alignment of the access size.
  always_comb begin
    off_in = i_alu_data[1:0];
    case (i_funct3[1:0])
      2'b01:   off_in = {i_alu_data[1], 1'b0};
      2'b10:   off_in = 2'b00;
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_in = ((i_funct3[1:0] == 2'b01) && i_alu_data[0]) ||
                       ((i_funct3[1:0] == 2'b10) && (i_alu_data[1:0] != 2'b00));
`else
  assign misalign_in = 1'b0;
`endif
  assign trap = misalign_in;

  assign timeout = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  lsu_align u_align (
    .st_funct3 (i_funct3),
    .st_off    (off_in),
    .st_data   (i_rs2_data),
    .be        (be_nx),
    .wdata     (wdata_nx),
    .ld_funct3 (funct3_q),
    .ld_off    (off_q),
    .rdata     (rdata_q),
    .ld_data   (ld_ext)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (bad_f3 || trap) ? DONE : REQ;
      REQ:     if (i_mem_ack || timeout) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= 32'h0;
      o_mem_wdata <= 32'h0;
      o_mem_be    <= 4'h0;
      tmo_cnt     <= '0;
      is_store    <= 1'b0;
      err_q       <= 1'b0;
      mis_q       <= 1'b0;
      funct3_q    <= 3'b0;
      off_q       <= 2'b0;
      rdata_q     <= 32'h0;
    end else begin
      o_mem_req <= (state_nx == REQ);
      // Counter is zero whenever not staying in REQ, so it is clear on entry.
      tmo_cnt   <= ((state == REQ) && (state_nx == REQ)) ? tmo_cnt + 1'b1 : '0;
      if (accept) begin
        o_mem_we    <= is_store_in;
        o_mem_addr  <= {i_alu_data[31:2], 2'b00};
        o_mem_wdata <= is_store_in ? wdata_nx : 32'h0;
        o_mem_be    <= be_nx;
        is_store    <= is_store_in;
        funct3_q    <= i_funct3;
        off_q       <= off_in;
        err_q       <= bad_f3;
        mis_q       <= trap && !bad_f3;
        rdata_q     <= 32'h0;
      end
      if (state == REQ) begin
        if (i_mem_ack)    rdata_q <= i_mem_rdata;
        else if (timeout) err_q   <= 1'b1;
      end
    end
  end

  assign o_ready    = (state == IDLE);
  assign o_done     = (state == DONE);
  assign o_err      = o_done && err_q;
  assign o_misalign = o_done && mis_q;
  assign o_ld_data  = (o_done && !is_store && !err_q && !mis_q) ? ld_ext : 32'h0;

endmodule
`default_nettype wire

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, is the number of cycles without i_mem_ack before an access is aborted.
REQ-002 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-003 i_rst  input  1  synchronous, active-high reset.
REQ-004 i_valid  input  1  an execute-stage operation is presented this cycle.
REQ-005 i_lsu_rden / i_lsu_wren  input  1 each  load / store request.
REQ-006 i_funct3  input  3  access size and sign (RV32I load/store encoding).
REQ-007 i_alu_data  input  32  effective address, taken from the ALU result.
REQ-008 i_rs2_data  input  32  store data.
REQ-009 o_ready  output  1  LSU is idle and accepts a request this cycle.
REQ-010 o_done  output  1  one-cycle pulse: the access has completed.
REQ-011 o_ld_data  output  32  load result after sign/zero extension; valid only while o_done is high.
REQ-012 o_err / o_misalign  output  1 each  one-cycle pulses coincident with o_done.
REQ-013 o_mem_req, o_mem_we (1), o_mem_addr (32), o_mem_wdata (32), o_mem_be (4)  outputs  memory request bus; all registered.
REQ-014 i_mem_ack (1), i_mem_rdata (32)  inputs  memory response.

Function
REQ-015 The FSM SHALL have three states: IDLE, REQ and DONE.
REQ-016 In IDLE, o_ready SHALL be 1; in every other state it SHALL be 0.
REQ-017 An accept SHALL occur in IDLE when i_valid=1 and (i_lsu_rden | i_lsu_wren)=1; otherwise the LSU SHALL stay in IDLE and ignore the inputs.
REQ-018 If i_lsu_rden and i_lsu_wren are both set, the request SHALL be treated as a store.
REQ-019 On accept, the LSU SHALL latch the address, size and sign, byte enables and lane-aligned write data, then enter REQ on the next cycle with o_mem_req=1.
REQ-020 o_mem_addr SHALL be {addr[31:2],2'b00}.
REQ-021 Stores: SB SHALL drive be=4'b0001<<addr[1:0] with the byte replicated on all lanes; SH SHALL drive be=4'b0011<<{addr[1],1'b0} with the halfword replicated; SW SHALL drive be=4'b1111.
REQ-022 Loads SHALL drive be according to the same size rules, with o_mem_we=0.
REQ-023 While in REQ, all o_mem_* outputs SHALL remain stable until the cycle in which i_mem_ack=1.
REQ-024 On ack, the LSU SHALL capture i_mem_rdata and go to DONE; o_mem_req SHALL be 0 from the next cycle.
REQ-025 In DONE, o_done=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-026 For loads in DONE, o_ld_data SHALL be the addressed byte/halfword from the captured word: LB/LH sign-extended, LBU/LHU zero-extended, LW the full word.
REQ-027 For stores, o_ld_data SHALL be 0.
REQ-028 Minimum latency: accept at cycle N, ack at N+1, o_done at N+2.
REQ-029 A timeout counter SHALL count REQ cycles; it SHALL clear on entry to REQ.
REQ-030 When the count reaches TIMEOUT_CYCLES without an ack, the LSU SHALL drop o_mem_req and go to DONE with o_err=1 and o_ld_data=0.
REQ-031 Undefined funct3 values (011, 110, 111; and 1xx for stores) SHALL skip the memory access and go directly to DONE with o_err=1.
REQ-032 i_mem_ack outside REQ SHALL be ignored.

Reset
REQ-033 While i_rst=1 at a clock edge, the next state SHALL be IDLE.
REQ-034 On reset, o_mem_req, o_mem_we, o_done, o_err and o_misalign SHALL be 0, and o_mem_addr, o_mem_wdata, o_mem_be, o_ld_data and the timeout counter SHALL be 0.
REQ-035 A reset asserted mid-REQ SHALL abandon the access with no o_done pulse; an ack arriving after the reset SHALL be ignored.

Configuration
REQ-036 With macro LSU_MISALIGN_TRAP_EN defined, a halfword access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL skip the memory access and go directly to DONE with o_misalign=1.
REQ-037 Without LSU_MISALIGN_TRAP_EN, the address low bits SHALL be forced to the natural alignment of the access size (cleared), and o_misalign SHALL be tied to 0.

Structure
REQ-038 The shared package SHALL hold the state enum (IDLE/REQ/DONE) and the funct3 size constants (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU).
REQ-039 A combinational sub-module lsu_align SHALL implement write-lane replication, byte-enable generation and load extraction/extension; the FSM and timeout counter SHALL stay in lsu.

Verification
REQ-040 SW, addr=0x104, data=0xDEADBEEF, ack after 2 cycles -> be=1111, addr=0x104, o_done 1 cycle after ack, o_ready back to 1.
REQ-041 LB, addr=0x203, rdata=0x80FF_FFFF -> o_ld_data=0xFFFF_FF80; LBU at the same address -> 0x0000_0080.
REQ-042 SH, addr=0x12, rs2=0x0000_ABCD -> be=1100, wdata=0xABCD_ABCD, addr=0x10.
REQ-043 LW with no ack for 16 cycles -> o_err=1, o_ld_data=0, o_mem_req low; a later stray ack is ignored.
REQ-044 LW, addr=0x101, with macro defined -> o_misalign=1 and no o_mem_req; without the macro -> addr=0x100 is issued normally.
REQ-045 Reset asserted in the second REQ cycle -> IDLE next cycle, o_mem_req=0, no o_done pulse.
